mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit, successor to the fixed 32-bit core MDU.
- Instantiated in the EX stage under the same stall/flush protocol.
- Generalised in operand width (XLEN) and multiplier radix (MUL_STEP bits retired per cycle).
- Adds single-cycle fast paths for divide-by-zero and signed overflow.
- Executes all eight RV M-extension operations, selected by funct3.

Parameters:
- XLEN, 32: operand/result width; even, ≥8.
- MUL_STEP, 4: multiplier bits consumed per CALC cycle; one of 1, 2, 4, 8; must divide XLEN.
- FAST_DIV, 1: 1 enables the div-by-zero/overflow shortcut; 0 runs the full iteration for these cases.

Ports:
- s_clk_i  in  1  clock
- s_resetn_i  in  1  asynchronous active-low reset
- s_stall_i  in  1  EX stage stalled by MA stage; instruction stays in EX
- s_flush_i  in  1  pipeline flush; abort current operation
- s_compute_i  in  1  EX holds an MDU instruction (held high for the instruction's whole EX residency)
- s_funct_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- s_operand1_i  in  XLEN  rs1 / dividend
- s_operand2_i  in  XLEN  rs2 / divisor
- s_finished_o  out  1  result valid this cycle
- s_result_o  out  XLEN  result (registered)

Behaviour:
- Reset: state IDLE, s_finished_o=0, s_result_o=0, all datapath registers 0.
- States: IDLE, CALC, DONE. s_finished_o = (state==DONE) && !s_flush_i.
- Flush has top priority: any state → IDLE on the next edge. s_result_o holds its value; counter cleared.
- IDLE, s_compute_i=1, no flush:
  - Latch funct and operands.
  - Convert signed operands to magnitude; record result sign.
  - MULHSU: op1 signed, op2 unsigned.
  - Load counter; go to CALC.
  - If FAST_DIV=1 and a div op with divisor==0 or (signed, op1==MIN, op2==−1): load s_result_o per the special-case rules below and go directly to DONE.
- CALC, multiply:
  - Each cycle, add (multiplicand × next MUL_STEP multiplier bits) into a 2·XLEN accumulator; shift right by MUL_STEP.
  - Runs K=XLEN/MUL_STEP cycles.
- CALC, divide:
  - Restoring radix-2; one quotient bit per cycle.
  - Runs K=XLEN cycles.
- Final CALC cycle: negate if the result sign is set, write s_result_o, go to DONE.
  - MUL: low XLEN bits. MULH/MULHSU/MULHU: high XLEN bits of the signed 2·XLEN product.
  - DIV/DIVU: quotient. REM/REMU: remainder; remainder takes the dividend's sign.
- Latency, counting the cycle IDLE first sees compute as cycle 0:
  - s_finished_o=1 in cycle K+1.
  - Fast path: cycle 1.
- Special cases (identical with FAST_DIV=0; the iteration must produce them):
  - x/0: quotient all-ones; remainder = dividend.
  - MIN/−1 signed: quotient MIN; remainder 0.
- DONE:
  - Stays in DONE while s_stall_i=1; s_finished_o and s_result_o are held.
  - s_stall_i=0 → IDLE next edge; the instruction leaves EX at that edge.
  - The next instruction's compute is first sampled in IDLE, so back-to-back ops cost one extra IDLE cycle.
- s_compute_i dropping in CALC without a flush: abort to IDLE. This is a protocol error and must be flagged by a bench assertion.
- s_stall_i during CALC: ignored; iteration continues.
- Reset mid-operation: immediate return to the reset state.
- Operand inputs are don't-care after cycle 0.

Test Plan:
- MUL 7 × −3, XLEN=32, MUL_STEP=4 → s_finished_o first high in cycle 9, s_result_o=0xFFFFFFEB. Repeat with MUL_STEP=1 → cycle 33.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF.
- DIVU 100/7 → 14 in cycle 33. REM −7 rem 2 → 0xFFFFFFFF. DIV −7/2 → 0xFFFFFFFD.
- DIV 5/0 → 0xFFFFFFFF in cycle 1. REMU 5/0 → 5. DIV 0x80000000/−1 → 0x80000000; REM of the same → 0. Repeat with FAST_DIV=0 → same values in cycle 33.
- s_flush_i in cycle 5 of a DIVU → IDLE in cycle 6, s_finished_o never asserts. A new MUL issued in cycle 7 completes normally with the correct result.
- s_stall_i high for 3 cycles at DONE → s_finished_o and s_result_o held for 4 cycles, then IDLE. An immediately following MULHU starts cleanly.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative RV M-extension multiply/divide unit for the EX stage.
// Radix-2^MUL_STEP shift-add multiply, restoring radix-2 divide, optional one-cycle div special cases.
module mdu_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 4,
  parameter int FAST_DIV = 1
) (
  input  logic            s_clk_i,
  input  logic            s_resetn_i,
  input  logic            s_stall_i,
  input  logic            s_flush_i,
  input  logic            s_compute_i,
  input  logic [2:0]      s_funct_i,
  input  logic [XLEN-1:0] s_operand1_i,
  input  logic [XLEN-1:0] s_operand2_i,
  output logic            s_finished_o,
  output logic [XLEN-1:0] s_result_o
);

  localparam int K_MUL = XLEN / MUL_STEP;
  localparam int CW    = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]        funct;
  logic              neg;
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;

  // Issue-time decode of the incoming instruction
  logic            in_div, sgn1, sgn2, op2_zero, ovf, fast, neg_in;
  logic [XLEN-1:0] mag1, mag2, fast_res;
  logic [CW-1:0]   cnt_load;

  always_comb begin
    in_div   = s_funct_i[2];
    sgn1     = s_operand1_i[XLEN-1] & (s_funct_i inside {3'd1, 3'd2, 3'd4, 3'd6});
    sgn2     = s_operand2_i[XLEN-1] & (s_funct_i inside {3'd1, 3'd4, 3'd6});
    mag1     = sgn1 ? -s_operand1_i : s_operand1_i;
    mag2     = sgn2 ? -s_operand2_i : s_operand2_i;
    op2_zero = (s_operand2_i == '0);
    ovf      = !s_funct_i[0] && (s_operand1_i == MIN_VAL) && (s_operand2_i == '1);
    fast     = (FAST_DIV != 0) && in_div && (op2_zero || ovf);
    if (s_funct_i[1]) fast_res = op2_zero ? s_operand1_i : '0;
    else              fast_res = op2_zero ? '1 : MIN_VAL;
    // Quotient of x/0 stays all-ones regardless of the dividend sign
    if (!in_div)           neg_in = sgn1 ^ sgn2;
    else if (s_funct_i[1]) neg_in = sgn1;
    else                   neg_in = (sgn1 ^ sgn2) && !op2_zero;
    cnt_load = in_div ? CW'(XLEN - 1) : CW'(K_MUL - 1);
  end

  // Multiply step: low acc half holds the remaining multiplier bits
  logic [XLEN+MUL_STEP-1:0] mprod, msum;
  logic [2*XLEN-1:0]        mul_next, prod;

  always_comb begin
    mprod = {{MUL_STEP{1'b0}}, mcand} * {{XLEN{1'b0}}, acc[MUL_STEP-1:0]};
    msum  = {{MUL_STEP{1'b0}}, acc[2*XLEN-1:XLEN]} + mprod;
  end

  generate
    if (MUL_STEP < XLEN) begin : g_shift
      assign mul_next = {msum, acc[XLEN-1:MUL_STEP]};
    end else begin : g_full
      assign mul_next = msum[2*XLEN-1:0];
    end
  endgenerate

  // Divide step: acc = {partial remainder, dividend/quotient}
  logic [XLEN:0]     trial;
  logic [2*XLEN-1:0] div_next, acc_nxt;
  logic [XLEN-1:0]   dres, fin_res;

  always_comb begin
    trial    = acc[2*XLEN-1:XLEN-1] - {1'b0, mcand};
    div_next = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                           : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_nxt  = funct[2] ? div_next : mul_next;
    prod     = neg ? -mul_next : mul_next;
    dres     = funct[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    if (funct[2])           fin_res = neg ? -dres : dres;
    else if (funct == 3'd0) fin_res = prod[XLEN-1:0];
    else                    fin_res = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (s_flush_i) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (s_compute_i) state_nxt = fast ? DONE : CALC;
        CALC:    if (!s_compute_i)    state_nxt = IDLE;
                 else if (cnt == '0)  state_nxt = DONE;
        DONE:    if (!s_stall_i) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    s_finished_o = (state == DONE) && !s_flush_i;
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      funct      <= '0;
      neg        <= 1'b0;
      mcand      <= '0;
      acc        <= '0;
      cnt        <= '0;
      s_result_o <= '0;
    end else if (s_flush_i) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (s_compute_i) begin
          funct <= s_funct_i;
          neg   <= neg_in;
          mcand <= in_div ? mag2 : mag1;
          acc   <= {{XLEN{1'b0}}, (in_div ? mag1 : mag2)};
          cnt   <= cnt_load;
          if (fast) s_result_o <= fast_res;
        end
        CALC: if (s_compute_i) begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) s_result_o <= fin_res;
        end else begin
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: three instances cover MUL_STEP=4/1 and FAST_DIV=1/0.
module tb_mdu_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        cmp [3];
  logic [2:0]  fn  [3];
  logic [31:0] op1 [3];
  logic [31:0] op2 [3];
  logic        fin [3];
  logic [31:0] res [3];
  logic        busy[3];
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(32), .MUL_STEP(4), .FAST_DIV(1)) u0 (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_stall_i(stall), .s_flush_i(flush),
    .s_compute_i(cmp[0]), .s_funct_i(fn[0]), .s_operand1_i(op1[0]), .s_operand2_i(op2[0]),
    .s_finished_o(fin[0]), .s_result_o(res[0]));

  mdu_iter #(.XLEN(32), .MUL_STEP(1), .FAST_DIV(1)) u1 (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_stall_i(stall), .s_flush_i(flush),
    .s_compute_i(cmp[1]), .s_funct_i(fn[1]), .s_operand1_i(op1[1]), .s_operand2_i(op2[1]),
    .s_finished_o(fin[1]), .s_result_o(res[1]));

  mdu_iter #(.XLEN(32), .MUL_STEP(4), .FAST_DIV(0)) u2 (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_stall_i(stall), .s_flush_i(flush),
    .s_compute_i(cmp[2]), .s_funct_i(fn[2]), .s_operand1_i(op1[2]), .s_operand2_i(op2[2]),
    .s_finished_o(fin[2]), .s_result_o(res[2]));

  // compute must stay high from issue until the result is seen, unless flushed
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      assert (!(busy[i] && !cmp[i] && !flush))
      else begin nerr++; $error("FAIL protocol: compute dropped mid-op on instance %0d", i); end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp)
    else begin nerr++; $error("FAIL %s: got %h expected %h", tag, got, exp); end
  endtask

  // Called at a negedge with the target instance in IDLE; returns at a negedge in IDLE.
  task automatic do_op(input int i, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int ecyc, input int nst, input string tag);
    int cyc;
    cmp[i] = 1'b1; fn[i] = f; op1[i] = a; op2[i] = b; busy[i] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin op1[i] = $urandom(); op2[i] = $urandom(); end
    end while (!fin[i] && cyc < 200);
    busy[i] = 1'b0;
    chk({tag, " latency"}, cyc, ecyc);
    chk({tag, " result"}, res[i], exp);
    for (int s = 0; s < nst; s++) begin
      stall = 1'b1;
      @(negedge clk);
      chk({tag, " stall fin"}, {31'd0, fin[i]}, 32'd1);
      chk({tag, " stall res"}, res[i], exp);
    end
    stall = 1'b0;
    cmp[i] = 1'b0;
    @(negedge clk);
    chk({tag, " leave"}, {31'd0, fin[i]}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      cmp[i] = 1'b0; fn[i] = 3'd0; op1[i] = '0; op2[i] = '0; busy[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset fin", {31'd0, fin[i]}, 32'd0);
      chk("reset res", res[i], 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    do_op(0, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 9, 0, "mul4 7*-3");
    do_op(1, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0, "mul1 7*-3");
    do_op(1, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0, "mulh1 min*min");
    do_op(0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 9, 0, "mulh min*min");
    do_op(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 9, 0, "mulhu max*max");
    do_op(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 9, 0, "mulhsu -1*max");
    do_op(0, 3'd0, 32'h12345678, 32'h00000010, 32'h23456780, 9, 0, "mul shift");

    do_op(0, 3'd5, 32'd100, 32'd7, 32'd14, 33, 0, "divu 100/7");
    do_op(0, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0, "rem -7%2");
    do_op(0, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0, "div -7/2");

    do_op(0, 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0, "fast div 5/0");
    do_op(0, 3'd7, 32'd5, 32'd0, 32'd5, 1, 0, "fast remu 5/0");
    do_op(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, "fast div min/-1");
    do_op(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 0, "fast rem min/-1");
    do_op(0, 3'd4, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 1, 0, "fast div -5/0");
    do_op(0, 3'd6, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1, 0, "fast rem -5/0");

    do_op(2, 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 33, 0, "slow div 5/0");
    do_op(2, 3'd7, 32'd5, 32'd0, 32'd5, 33, 0, "slow remu 5/0");
    do_op(2, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 0, "slow div min/-1");
    do_op(2, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33, 0, "slow rem min/-1");
    do_op(2, 3'd4, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 33, 0, "slow div -5/0");
    do_op(2, 3'd6, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 33, 0, "slow rem -5/0");

    // Flush a DIVU in cycle 5; result register must keep the prior value
    cmp[0] = 1'b1; fn[0] = 3'd5; op1[0] = 32'd100; op2[0] = 32'd7; busy[0] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("flush no fin", {31'd0, fin[0]}, 32'd0);
    end
    flush = 1'b1; cmp[0] = 1'b0; busy[0] = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("flush idle fin", {31'd0, fin[0]}, 32'd0);
    chk("flush res hold", res[0], 32'hFFFFFFFB);
    @(negedge clk);
    do_op(0, 3'd0, 32'd12, 32'hFFFFFFFB, 32'hFFFFFFC4, 9, 0, "mul after flush");

    // Stall at DONE for 3 cycles, then an immediate MULHU
    do_op(0, 3'd0, 32'd3, 32'd4, 32'd12, 9, 3, "mul stalled");
    do_op(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 9, 0, "mulhu after stall");

    // Reset in the middle of an operation
    cmp[0] = 1'b1; fn[0] = 3'd5; op1[0] = 32'd100; op2[0] = 32'd7; busy[0] = 1'b1;
    repeat (4) @(negedge clk);
    busy[0] = 1'b0; cmp[0] = 1'b0; rst_n = 1'b0;
    #1;
    chk("midop reset res", res[0], 32'd0);
    chk("midop reset fin", {31'd0, fin[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
